// File: rtl/result_stream_reader.sv
// Drains a synchronous-read result RAM from address 0 up to a captured limit,
// presenting each word on a valid/ready stream with a last flag and a done pulse.
module result_stream_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [ADDR_W-1:0] lim_q,        lim_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic              out_valid_q,  out_valid_d;
    logic              out_last_q,   out_last_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lim_d        = lim_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        word_count_d = word_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lim_d        = last_addr;
                    addr_d       = '0;
                    word_count_d = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // RAM data for addr_q is present this cycle, one after the read strobe
                out_data_d  = ram_rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (addr_q == lim_q);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    word_count_d = word_count_q + 1'b1;
                    if (addr_q == lim_q) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            lim_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lim_q        <= lim_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
        end
    end

    // Address is only driven while a drain is in progress so IDLE presents zero
    assign ram_rd_en  = (state_q == S_READ);
    assign ram_addr   = (state_q == S_IDLE) ? '0 : addr_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader with a synchronous-read RAM model.
module tb_result_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  last_addr = '0;
    logic        ram_rd_en;
    logic [3:0]  ram_addr;
    logic [15:0] ram_rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;

    logic [15:0] mem [16];
    logic [15:0] ram_q = '0;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          over_cnt = 0;
    int          cur_last = 0;

    result_stream_reader #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .last_addr(last_addr),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_q  <= mem[ram_addr];
            rd_cnt <= rd_cnt + 1;
            if (int'(ram_addr) > cur_last) over_cnt <= over_cnt + 1;
        end
    end
    assign ram_rd_data = ram_q;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next out_valid; returns negedges elapsed
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic drain(input int last, input int stall_w, input int start_w);
        int cyc;
        int dc0;
        int rc0;
        int oc0;
        logic [15:0] held;
        dc0 = done_cnt;
        rc0 = rd_cnt;
        oc0 = over_cnt;
        cur_last = last;
        @(negedge clk);
        last_addr = 4'(last);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        last_addr = ~4'(last);
        for (int w = 0; w <= last; w++) begin
            wait_valid(cyc);
            chk("valid", 32'(out_valid), 32'd1);
            chk("spacing", cyc, 32'd3);
            chk("data", 32'(out_data), 32'(mem[w]));
            chk("last", 32'(out_last), 32'(w == last));
            chk("busy_run", 32'(busy), 32'd1);
            if (w == stall_w) begin
                out_ready = 1'b0;
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(held));
                    chk("stall_rd", 32'(ram_rd_en), 32'd0);
                end
                out_ready = 1'b1;
            end
            if (w == start_w) begin
                start = 1'b1;
                last_addr = 4'd0;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        chk("done_hi", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_lo", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("word_count", 32'(word_count), 32'(last + 1));
        chk("done_pulses", done_cnt - dc0, 32'd1);
        chk("reads", rd_cnt - rc0, 32'(last + 1));
        chk("addr_range", over_cnt - oc0, 32'd0);
    endtask

    task automatic load_seq();
        mem[0] = 16'h0011;
        mem[1] = 16'h0022;
        mem[2] = 16'h0033;
        mem[3] = 16'h0044;
    endtask

    initial begin
        int cyc;
        int dc0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        #3 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        load_seq();
        drain(3, -1, -1);
        drain(3, 1, -1);

        mem[0] = 16'hBEEF;
        drain(0, -1, -1);

        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        drain(15, -1, -1);

        load_seq();
        drain(3, -1, 2);

        // Reset in the middle of a drain, while word 1 is held
        dc0 = done_cnt;
        cur_last = 3;
        @(negedge clk);
        last_addr = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(cyc);
        chk("mid_w0", 32'(out_data), 32'h0011);
        @(posedge clk);
        #1;
        wait_valid(cyc);
        out_ready = 1'b0;
        chk("mid_w1", 32'(out_data), 32'h0022);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(word_count), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_no_pulse", done_cnt - dc0, 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        drain(3, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_stream_reader.md
Name: result_stream_reader

Overview:
- Drains the result RAM after the compute controller has filled it.
- On a start pulse, reads addresses 0..last_addr in order from the synchronous-read RAM.
- Presents each word on a valid/ready output stream and flags the final word.
- Sits on the read port of the result RAM and replaces file dumping as the path results take off-chip.

Parameters:
- DATA_W, 16, width of one RAM word and of out_data.
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a drain; sampled only in IDLE.
- last_addr  input  ADDR_W  address of the final word; captured when start is accepted.
- ram_rd_en  output  1  RAM read enable.
- ram_addr  output  ADDR_W  RAM read address.
- ram_rd_data  input  DATA_W  RAM read data, valid the cycle after ram_rd_en.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accepts when high together with out_valid.
- out_last  output  1  high with out_valid on the final word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.
- word_count  output  ADDR_W+1  words accepted in the current or most recent drain.

Behaviour:
- Reset (rst low, asynchronous) forces the following, regardless of state:
  - state = IDLE
  - ram_addr = 0, ram_rd_en = 0
  - out_data = 0, out_valid = 0, out_last = 0
  - busy = 0, done = 0, word_count = 0
- States: IDLE, READ, CAPTURE, HOLD, FIN.
- IDLE:
  - All outputs low except the held out_data and word_count.
  - When start = 1: capture last_addr into lim, set addr = 0, clear word_count, go to READ.
- READ:
  - ram_rd_en = 1, ram_addr = addr (combinational from the registered addr).
  - Always go to CAPTURE.
- CAPTURE:
  - ram_rd_en = 0.
  - On the edge: out_data <= ram_rd_data, out_valid <= 1, out_last <= (addr == lim).
  - Go to HOLD.
- HOLD:
  - out_valid and out_data stay stable until the handshake.
  - out_ready = 0: stay in HOLD.
  - out_ready = 1:
    - out_valid <= 0, out_last <= 0, word_count <= word_count + 1.
    - If addr == lim, go to FIN; otherwise addr <= addr + 1 and go to READ.
- FIN:
  - done = 1 for exactly this cycle, busy = 1.
  - Always go to IDLE.
- Latency and throughput:
  - start accepted at edge k gives out_valid high from edge k+2.
  - With out_ready held high, one word every 3 cycles.
  - done is high in the cycle after the final accept edge.
- Boundaries:
  - lim = 0: exactly one word, out_last set on it.
  - lim = 2**ADDR_W-1: all words are read, and addr never wraps because it stops at lim. word_count reaches 2**ADDR_W, hence the extra bit.
  - start while busy: ignored, and lim does not change.
  - A start held high across FIN→IDLE is accepted again in IDLE. The upstream must therefore pulse start.
  - last_addr changes during a drain: no effect.
  - out_ready high outside HOLD: ignored.
  - rst asserted mid-drain: immediate return to reset values. No done pulse, and the partial word is dropped.
- Arithmetic: addr and word_count increment modulo their width. Overflow cannot occur within a legal drain.

Test Plan:
- Reset, then RAM[0..3] = 0x0011, 0x0022, 0x0033, 0x0044, last_addr = 3, pulse start, out_ready = 1:
  - Stream is 0x0011, 0x0022, 0x0033, 0x0044.
  - out_last only on 0x0044.
  - First out_valid 2 cycles after the start edge; words spaced 3 cycles apart.
  - done pulses once; word_count = 4.
- Same data with out_ready held low for 5 cycles on word 1:
  - out_valid = 1 and out_data = 0x0022 stay stable for all 5 cycles.
  - No RAM read occurs during the stall.
  - Final stream is unchanged.
- last_addr = 0, RAM[0] = 0xBEEF:
  - Single word 0xBEEF with out_last = 1.
  - done follows; word_count = 1.
- last_addr = 15 with RAM[i] = i:
  - Stream is 0..15.
  - word_count = 16; ram_addr never exceeds 15.
- Pulse start again while HOLD is on word 2:
  - Ignored; the drain completes normally with a single done.
- Pull rst low while in HOLD on word 1:
  - out_valid = 0, busy = 0, word_count = 0 immediately, with no done.
  - A new start after rst is released restarts the drain from address 0.
